// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive core.
//   rx_state_e     : receive FSM states
//   *_BIT/DATA_LSB : field offsets inside a receive FIFO entry
//   data_bits_eff  : maps the data-width setting to 5..9 (out of range -> 8)
//   char_bits      : full character length in bits (start+data+parity+stop)
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH,
    ST_BRK_WAIT
  } rx_state_e;

  localparam int BRK_BIT  = 0;
  localparam int FE_BIT   = 1;
  localparam int PE_BIT   = 2;
  localparam int DATA_LSB = 3;

  function automatic logic [3:0] data_bits_eff(input logic [3:0] cfg);
    return (cfg >= 4'd5 && cfg <= 4'd9) ? cfg : 4'd8;
  endfunction

  function automatic int unsigned char_bits(input logic [3:0] cfg_data_bits,
                                            input logic       parity_en,
                                            input logic       stop2);
    return 32'd2 + 32'(data_bits_eff(cfg_data_bits)) + 32'(parity_en) + 32'(stop2);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Register-block side of the UART receive core.
//   master : register block (drives rf_pop, rx_reset, rx_lsr_mask)
//   slave  : receive core (drives FIFO head/status, timeout, break, busy)
interface uart_rx_param_if #(
  parameter int MAX_DATA_W = 9,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  rf_pop;
  logic                  rx_reset;
  logic                  rx_lsr_mask;
  logic [MAX_DATA_W+2:0] rf_data_out;
  logic [CNT_W-1:0]      rf_count;
  logic                  rf_overrun;
  logic                  rf_error_bit;
  logic                  rx_timeout;
  logic                  rx_break;
  logic                  rx_busy;

  modport master (
    output rf_pop, rx_reset, rx_lsr_mask,
    input  rf_data_out, rf_count, rf_overrun, rf_error_bit, rx_timeout, rx_break, rx_busy
  );

  modport slave (
    input  rf_pop, rx_reset, rx_lsr_mask,
    output rf_data_out, rf_count, rf_overrun, rf_error_bit, rx_timeout, rx_break, rx_busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with overrun flag and error-entry tracking.
//   clk, rst_n : clock, async active-low reset
//   push/din   : write an entry (dropped and flagged as overrun when full)
//   pop        : remove head (ignored when empty)
//   flush      : synchronous empty, clears error tracking
//   lsr_mask   : clears overrun (wins over a coincident set)
//   dout       : head entry, 0 when empty; count: occupancy
//   error_bit  : some stored entry carries parity/framing/break
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   lsr_mask,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  output logic                   error_bit
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    err_cnt;
  logic             do_pop, do_push, full, din_err, head_err;

  assign do_pop   = pop && (count != '0);
  assign full     = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push && (!full || do_pop);
  assign din_err  = din[PE_BIT] | din[FE_BIT] | din[BRK_BIT];
  assign head_err = mem[rd_ptr][PE_BIT] | mem[rd_ptr][FE_BIT] | mem[rd_ptr][BRK_BIT];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count + CW'(do_push) - CW'(do_pop);
      err_cnt <= err_cnt + CW'(do_push && din_err) - CW'(do_pop && head_err);
    end
  end

  // NOTE: the storage array has no reset; only pointers and counts do, and
  // the head output is forced to 0 while empty so no stale data escapes.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       overrun <= 1'b0;
    else if (lsr_mask)                overrun <= 1'b0;
    else if (push && !do_push && !flush) overrun <= 1'b1;
  end

  assign dout      = (count != '0) ? mem[rd_ptr] : '0;
  assign error_bit = (err_cnt != '0);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receive core (16550-compatible).
//   clk, wb_rst_ni : clock, async active-low reset
//   enable         : one-clk oversample tick
//   srx_pad_i      : serial input, idle high
//   cfg_*          : data bits (5..9), parity enable/even/stick, two stop bits
//   rb (slave)     : FIFO head/count/status, timeout, break, busy; pop,
//                    flush and LSR-mask controls from the register block
// Optional build macro UART_RX_MAJORITY_EN: each sample point becomes a
// 2-of-3 vote over ticks mid-1, mid, mid+1.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_W    = 9,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic       clk,
  input  logic       wb_rst_ni,
  input  logic       enable,
  input  logic       srx_pad_i,
  input  logic [3:0] cfg_data_bits,
  input  logic       cfg_parity_en,
  input  logic       cfg_even_parity,
  input  logic       cfg_stick_parity,
  input  logic       cfg_stop2,
  uart_rx_param_if.slave rb
);
  localparam int CNT_W    = $clog2(OVERSAMPLE);
  localparam int IDX_W    = $clog2(MAX_DATA_W);
  localparam int ENTRY_W  = MAX_DATA_W + 3;
  localparam int TOUT_MAX = TIMEOUT_CHARS * 13 * OVERSAMPLE;
  localparam int TOUT_W   = $clog2(TOUT_MAX + 1);

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the tick after mid-bit, so every sample point slips one tick.
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(OVERSAMPLE/2);
`else
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(OVERSAMPLE/2 - 1);
`endif
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(OVERSAMPLE - 1);

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [MAX_DATA_W-1:0] sr_q;
  logic                  par_q, pe_q, fe_q, brk_q;
  logic                  rx_break_q;
  logic [TOUT_W-1:0]     tout_q, tout_reload;
  logic [ENTRY_W-1:0]    entry;
  logic                  sample, cnt_zero, last_bit, exp_par, rf_push, pop_eff;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni)  hist_q <= 2'b11;
    else if (enable) hist_q <= {hist_q[0], srx_pad_i};
  end
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & srx_pad_i) | (hist_q[0] & srx_pad_i);
`else
  assign sample = srx_pad_i;
`endif

  assign cnt_zero = (cnt_q == '0);
  assign last_bit = (32'(idx_q) + 32'd1) == 32'(data_bits_eff(cfg_data_bits));
  // Unused upper data bits are 0, so the reduction covers only real data.
  assign exp_par  = cfg_stick_parity ? ~cfg_even_parity : ((^sr_q) ^ ~cfg_even_parity);

  // FSM state register
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (enable && !srx_pad_i) state_d = ST_START;
      ST_START:    if (enable && cnt_zero)   state_d = sample ? ST_IDLE : ST_DATA;
      ST_DATA:     if (enable && cnt_zero && last_bit)
                     state_d = cfg_parity_en ? ST_PARITY : ST_STOP;
      ST_PARITY:   if (enable && cnt_zero)   state_d = ST_STOP;
      ST_STOP:     if (enable && cnt_zero)   state_d = ST_PUSH;
      ST_PUSH:     state_d = brk_q ? ST_BRK_WAIT : ST_IDLE;
      ST_BRK_WAIT: if (enable && srx_pad_i)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rf_push    = (state_q == ST_PUSH);
    rb.rx_busy = (state_q != ST_IDLE);
  end

  // Bit timing and character assembly
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= START_LOAD;
      idx_q <= '0;
      sr_q  <= '0;
      par_q <= 1'b0;
      pe_q  <= 1'b0;
      fe_q  <= 1'b0;
      brk_q <= 1'b0;
    end else if (enable) begin
      unique case (state_q)
        ST_IDLE: cnt_q <= START_LOAD;
        ST_START:
          if (cnt_zero) begin
            cnt_q <= BIT_LOAD;
            idx_q <= '0;
            sr_q  <= '0;
            par_q <= 1'b0;
            pe_q  <= 1'b0;
            fe_q  <= 1'b0;
            brk_q <= 1'b0;
          end else cnt_q <= cnt_q - CNT_W'(1);
        ST_DATA:
          if (cnt_zero) begin
            cnt_q       <= BIT_LOAD;
            sr_q[idx_q] <= sample;
            idx_q       <= idx_q + IDX_W'(1);
          end else cnt_q <= cnt_q - CNT_W'(1);
        ST_PARITY:
          if (cnt_zero) begin
            cnt_q <= BIT_LOAD;
            par_q <= sample;
            pe_q  <= sample ^ exp_par;
          end else cnt_q <= cnt_q - CNT_W'(1);
        ST_STOP:
          if (cnt_zero) begin
            cnt_q <= START_LOAD;
            fe_q  <= ~sample;
            brk_q <= (sr_q == '0) && (!cfg_parity_en || !par_q) && !sample;
          end else cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    entry                         = '0;
    entry[ENTRY_W-1:DATA_LSB]     = sr_q;
    entry[PE_BIT]                 = pe_q;
    entry[FE_BIT]                 = fe_q;
    entry[BRK_BIT]                = brk_q;
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (wb_rst_ni),
    .push      (rf_push),
    .din       (entry),
    .pop       (rb.rf_pop),
    .flush     (rb.rx_reset),
    .lsr_mask  (rb.rx_lsr_mask),
    .dout      (rb.rf_data_out),
    .count     (rb.rf_count),
    .overrun   (rb.rf_overrun),
    .error_bit (rb.rf_error_bit)
  );

  // Sticky break flag; the mask clear wins over a coincident break push.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni)            rx_break_q <= 1'b0;
    else if (rb.rx_lsr_mask)   rx_break_q <= 1'b0;
    else if (rf_push && brk_q) rx_break_q <= 1'b1;
  end
  assign rb.rx_break = rx_break_q;

  // Character timeout: restarts on any FIFO activity or while empty.
  assign pop_eff     = rb.rf_pop && (rb.rf_count != '0);
  assign tout_reload = TOUT_W'(TIMEOUT_CHARS * char_bits(cfg_data_bits, cfg_parity_en, cfg_stop2) * OVERSAMPLE);

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                                    tout_q <= TOUT_W'(TOUT_MAX);
    else if (rf_push || pop_eff || rb.rf_count == '0)  tout_q <= tout_reload;
    else if (enable && tout_q != '0)                   tout_q <= tout_q - TOUT_W'(1);
  end

  assign rb.rx_timeout = (tout_q == '0) && (rb.rf_count != '0);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param (OVERSAMPLE=16, FIFO_DEPTH=16,
// TIMEOUT_CHARS=4). One oversample tick every 4 clocks; serial bits are
// driven as 16-tick cells starting just after a tick edge.
module tb_uart_rx_param;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       wb_rst_ni;
  logic       enable;
  logic       srx;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en, cfg_even_parity, cfg_stick_parity, cfg_stop2;
  logic [1:0] div;

  int checks = 0;
  int errors = 0;

  uart_rx_param_if #(.MAX_DATA_W(9), .FIFO_DEPTH(16)) rb ();

  uart_rx_param #(
    .OVERSAMPLE(16), .MAX_DATA_W(9), .FIFO_DEPTH(16), .TIMEOUT_CHARS(4)
  ) dut (
    .clk              (clk),
    .wb_rst_ni        (wb_rst_ni),
    .enable           (enable),
    .srx_pad_i        (srx),
    .cfg_data_bits    (cfg_data_bits),
    .cfg_parity_en    (cfg_parity_en),
    .cfg_even_parity  (cfg_even_parity),
    .cfg_stick_parity (cfg_stick_parity),
    .cfg_stop2        (cfg_stop2),
    .rb               (rb)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) div <= 2'd0;
    else            div <= div + 2'd1;
  end
  assign enable = (div == 2'd3);

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Return #1 after the next tick edge.
  task automatic tick();
    do @(negedge clk); while (!enable);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    srx = b;
    repeat (OS) tick();
  endtask

  task automatic send_frame(input logic [8:0] data, input int nbits,
                            input bit par_en, input bit par_bit, input bit stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    if (par_en) send_bit(par_bit);
    send_bit(stop_bit);
    srx = 1'b1;
  endtask

  task automatic pop_one();
    rb.rf_pop = 1'b1;
    @(posedge clk); #1;
    rb.rf_pop = 1'b0;
  endtask

  task automatic lsr_mask();
    rb.rx_lsr_mask = 1'b1;
    @(posedge clk); #1;
    rb.rx_lsr_mask = 1'b0;
  endtask

  task automatic flush();
    rb.rx_reset = 1'b1;
    @(posedge clk); #1;
    rb.rx_reset = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] bits, input bit pen, input bit even, input bit stick);
    cfg_data_bits    = bits;
    cfg_parity_en    = pen;
    cfg_even_parity  = even;
    cfg_stick_parity = stick;
  endtask

  initial begin
    int n;
    wb_rst_ni = 1'b0;
    srx = 1'b1;
    cfg_stop2 = 1'b0;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    rb.rf_pop = 1'b0;
    rb.rx_reset = 1'b0;
    rb.rx_lsr_mask = 1'b0;
    repeat (3) @(posedge clk);
    #1 wb_rst_ni = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_data",    32'(rb.rf_data_out),  32'h0);
    check("rst_count",   32'(rb.rf_count),     32'd0);
    check("rst_overrun", 32'(rb.rf_overrun),   32'd0);
    check("rst_errbit",  32'(rb.rf_error_bit), 32'd0);
    check("rst_timeout", 32'(rb.rx_timeout),   32'd0);
    check("rst_break",   32'(rb.rx_break),     32'd0);
    check("rst_busy",    32'(rb.rx_busy),      32'd0);

    // 8N1 0xA5 -> {0x0A5, 000}
    send_frame(9'h0A5, 8, 0, 0, 1);
    check("8n1_count",  32'(rb.rf_count),     32'd1);
    check("8n1_data",   32'(rb.rf_data_out),  32'h528);
    check("8n1_errbit", 32'(rb.rf_error_bit), 32'd0);
    check("8n1_busy",   32'(rb.rx_busy),      32'd0);
    pop_one();
    check("8n1_pop_count", 32'(rb.rf_count),    32'd0);
    check("8n1_pop_data",  32'(rb.rf_data_out), 32'h0);

    // 9E1 0x1C3 (5 ones -> even parity bit 1), send 0 -> parity error
    set_cfg(4'd9, 1'b1, 1'b1, 1'b0);
    send_frame(9'h1C3, 9, 1, 0, 1);
    check("9e1_bad_data",   32'(rb.rf_data_out),  32'hE1C);
    check("9e1_bad_errbit", 32'(rb.rf_error_bit), 32'd1);
    pop_one();
    check("9e1_errbit_clr", 32'(rb.rf_error_bit), 32'd0);

    // 8O1 0x5A (4 ones -> odd parity bit 1), correct
    set_cfg(4'd8, 1'b1, 1'b0, 1'b0);
    send_frame(9'h05A, 8, 1, 1, 1);
    check("8o1_good_data", 32'(rb.rf_data_out), 32'h2D0);
    pop_one();

    // Stick parity with even=1 expects 0; send 1 -> parity error
    set_cfg(4'd8, 1'b1, 1'b1, 1'b1);
    send_frame(9'h05A, 8, 1, 1, 1);
    check("stick_data", 32'(rb.rf_data_out), 32'h2D4);
    pop_one();

    // 5N1 0x15
    set_cfg(4'd5, 1'b0, 1'b0, 1'b0);
    send_frame(9'h015, 5, 0, 0, 1);
    check("5n1_data", 32'(rb.rf_data_out), 32'h0A8);
    pop_one();

    // Out-of-range width (12) behaves as 8 bits
    set_cfg(4'd12, 1'b0, 1'b0, 1'b0);
    send_frame(9'h0C3, 8, 0, 0, 1);
    check("bits12_data",  32'(rb.rf_data_out), 32'h618);
    check("bits12_count", 32'(rb.rf_count),    32'd1);
    pop_one();
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);

    // Framing error: stop bit 0 with nonzero data, not a break
    send_frame(9'h081, 8, 0, 0, 0);
    repeat (20) tick();
    check("fe_data",  32'(rb.rf_data_out), 32'h40A);
    check("fe_count", 32'(rb.rf_count),    32'd1);
    check("fe_break", 32'(rb.rx_break),    32'd0);
    pop_one();

    // 6-tick glitch: false start, no push
    srx = 1'b0;
    repeat (3) tick();
    check("glitch_busy_mid", 32'(rb.rx_busy), 32'd1);
    repeat (3) tick();
    srx = 1'b1;
    repeat (20) tick();
    check("glitch_busy", 32'(rb.rx_busy),  32'd0);
    check("glitch_count", 32'(rb.rf_count), 32'd0);

    // Break: low for 12 bit times
    srx = 1'b0;
    repeat (12*OS) tick();
    check("brk_wait_busy", 32'(rb.rx_busy), 32'd1);
    srx = 1'b1;
    repeat (4) tick();
    check("brk_count",  32'(rb.rf_count),     32'd1);
    check("brk_data",   32'(rb.rf_data_out),  32'h003);
    check("brk_flag",   32'(rb.rx_break),     32'd1);
    check("brk_errbit", 32'(rb.rf_error_bit), 32'd1);
    check("brk_busy",   32'(rb.rx_busy),      32'd0);
    pop_one();
    send_frame(9'h03C, 8, 0, 0, 1);
    check("post_brk_data",  32'(rb.rf_data_out), 32'h1E0);
    check("post_brk_count", 32'(rb.rf_count),    32'd1);
    check("brk_sticky",     32'(rb.rx_break),    32'd1);
    lsr_mask();
    check("brk_mask", 32'(rb.rx_break), 32'd0);
    pop_one();

    // Overrun: 17 frames, no pops
    for (int i = 0; i < 16; i++) send_frame(9'(i + 1), 8, 0, 0, 1);
    check("full_count",   32'(rb.rf_count),   32'd16);
    check("full_overrun", 32'(rb.rf_overrun), 32'd0);
    send_frame(9'h011, 8, 0, 0, 1);
    check("ovr_count",   32'(rb.rf_count),    32'd16);
    check("ovr_flag",    32'(rb.rf_overrun),  32'd1);
    check("ovr_head",    32'(rb.rf_data_out), 32'h008);
    lsr_mask();
    check("ovr_mask",    32'(rb.rf_overrun),  32'd0);
    pop_one();
    check("ovr_pop_count", 32'(rb.rf_count),    32'd15);
    check("ovr_pop_head",  32'(rb.rf_data_out), 32'h010);

    // Push and pop in the same clock
    n = 0;
    fork
      send_frame(9'h055, 8, 0, 0, 1);
      begin
        while (!dut.rf_push && n < 2000) begin @(negedge clk); n++; end
        rb.rf_pop = 1'b1;
        @(posedge clk); #1;
        rb.rf_pop = 1'b0;
      end
    join
    check("pushpop_seen",  32'(n < 2000),        32'd1);
    check("pushpop_count", 32'(rb.rf_count),     32'd15);
    check("pushpop_head",  32'(rb.rf_data_out),  32'h018);
    check("pushpop_ovr",   32'(rb.rf_overrun),   32'd0);
    flush();
    check("flush_count",  32'(rb.rf_count),     32'd0);
    check("flush_errbit", 32'(rb.rf_error_bit), 32'd0);
    check("flush_data",   32'(rb.rf_data_out),  32'h0);

    // Character timeout: 4 * 10 * 16 = 640 ticks after the push
    n = 0;
    fork
      send_frame(9'h081, 8, 0, 0, 1);
      begin
        int w = 0;
        while (rb.rf_count == '0 && w < 2000) begin @(negedge clk); w++; end
        while (!rb.rx_timeout && n < 1000) begin tick(); n++; end
      end
    join
    check("tout_ticks", 32'(n), 32'd640);
    check("tout_flag",  32'(rb.rx_timeout), 32'd1);
    pop_one();
    check("tout_clear", 32'(rb.rx_timeout), 32'd0);
    check("tout_count", 32'(rb.rf_count),   32'd0);

    // Reset mid-frame aborts, nothing pushed
    srx = 1'b0;
    repeat (40) tick();
    check("midrst_busy_pre", 32'(rb.rx_busy), 32'd1);
    wb_rst_ni = 1'b0;
    #1;
    check("midrst_busy", 32'(rb.rx_busy), 32'd0);
    srx = 1'b1;
    @(posedge clk); #1;
    wb_rst_ni = 1'b1;
    repeat (200) tick();
    check("midrst_count", 32'(rb.rf_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
